full_adder: RTL and testbench



---
 rtl/full_adder.sv | 42 ++++
 tb/tb_full_adder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// Single-bit full adder with registered result, carry-chain register and input coverage.
// Latency: S/Cout combinational; S_q/Cout_q/carry_q/cov one cycle after the sampling edge.
// Backpressure: none; every rising edge out of reset samples the inputs.
module full_adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       A,
    input  logic       B,
    input  logic       Cin,
    output logic       S,
    output logic       Cout,
    input  logic       chain_en,
    output logic       S_q,
    output logic       Cout_q,
    output logic       carry_q,
    output logic [7:0] cov
);

    logic [2:0] combo;

    assign S     = A ^ B ^ Cin;
    assign Cout  = (A & B) | (A & Cin) | (B & Cin);
    assign combo = {A, B, Cin};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_q     <= 1'b0;
            Cout_q  <= 1'b0;
            carry_q <= 1'b0;
            cov     <= 8'h00;
        end else begin
            S_q        <= S;
            Cout_q     <= Cout;
            cov[combo] <= 1'b1;
            // Bit-serial addition feeds carry_q back into Cin, one bit per enabled edge.
            if (chain_en) begin
                carry_q <= Cout;
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder: combinational sweep, reset, registered path,
// bit-serial add, carry hold and sticky coverage.
module tb_full_adder;

    logic       clk;
    logic       rst_n;
    logic       A;
    logic       B;
    logic       Cin;
    logic       S;
    logic       Cout;
    logic       chain_en;
    logic       S_q;
    logic       Cout_q;
    logic       carry_q;
    logic [7:0] cov;

    logic       run;
    int         total;
    int         bad;

    full_adder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .S        (S),
        .Cout     (Cout),
        .chain_en (chain_en),
        .S_q      (S_q),
        .Cout_q   (Cout_q),
        .carry_q  (carry_q),
        .cov      (cov)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (run) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic a, input logic b, input logic c, input logic ce);
        A        = a;
        B        = b;
        Cin      = c;
        chain_en = ce;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] s_tab;
        logic [7:0] c_tab;
        logic [2:0] v;
        logic [2:0] res;

        total    = 0;
        bad      = 0;
        run      = 1'b0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        // Truth table, indexed by {A,B,Cin}.
        s_tab = 8'h96;
        c_tab = 8'hE8;

        // Combinational sweep with the clock stopped and reset held.
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            drive(v[2], v[1], v[0], 1'b0);
            #1;
            chk($sformatf("comb_S_%0d", i), {7'b0, S}, {7'b0, s_tab[i]});
            chk($sformatf("comb_Cout_%0d", i), {7'b0, Cout}, {7'b0, c_tab[i]});
        end

        // Reset values, with clock running and inputs 111.
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        run = 1'b1;
        tick();
        tick();
        chk("rst_S_q", {7'b0, S_q}, 8'h00);
        chk("rst_Cout_q", {7'b0, Cout_q}, 8'h00);
        chk("rst_carry_q", {7'b0, carry_q}, 8'h00);
        chk("rst_cov", cov, 8'h00);
        chk("rst_S_comb", {7'b0, S}, 8'h01);
        chk("rst_Cout_comb", {7'b0, Cout}, 8'h01);

        // Release reset away from the rising edge, then registered path.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("reg110_S_q", {7'b0, S_q}, 8'h00);
        chk("reg110_Cout_q", {7'b0, Cout_q}, 8'h01);
        chk("reg110_cov", cov, 8'h40);
        chk("reg110_carry_q", {7'b0, carry_q}, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("reg100_S_q", {7'b0, S_q}, 8'h01);
        chk("reg100_Cout_q", {7'b0, Cout_q}, 8'h00);
        chk("reg100_cov", cov, 8'h50);

        // Bit-serial 3 + 1, LSB first, Cin taken from carry_q.
        res = 3'b000;
        drive(1'b1, 1'b1, carry_q, 1'b1);
        #1;
        res[0] = S;
        chk("ser_b0_S", {7'b0, S}, 8'h00);
        tick();
        chk("ser_b0_carry", {7'b0, carry_q}, 8'h01);
        drive(1'b1, 1'b0, carry_q, 1'b1);
        #1;
        res[1] = S;
        chk("ser_b1_S", {7'b0, S}, 8'h00);
        tick();
        chk("ser_b1_carry", {7'b0, carry_q}, 8'h01);
        drive(1'b0, 1'b0, carry_q, 1'b1);
        #1;
        res[2] = S;
        chk("ser_b2_S", {7'b0, S}, 8'h01);
        tick();
        chk("ser_b2_carry", {7'b0, carry_q}, 8'h00);
        chk("ser_result", {5'b0, res}, 8'h04);
        chk("ser_cov", cov, 8'h72);

        // chain_en low with 111: carry_q must hold 0; a pulse between edges is ignored.
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        #2;
        chain_en = 1'b0;
        tick();
        chk("hold0_carry", {7'b0, carry_q}, 8'h00);
        chk("hold0_Cout_q", {7'b0, Cout_q}, 8'h01);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk("load1_carry", {7'b0, carry_q}, 8'h01);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("hold1_carry", {7'b0, carry_q}, 8'h01);
        chk("hold_cov", cov, 8'hF3);

        // Asynchronous reset mid-cycle clears carry and coverage immediately.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_carry", {7'b0, carry_q}, 8'h00);
        chk("async_cov", cov, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Coverage sweep, one combination per cycle.
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            drive(v[2], v[1], v[0], 1'b0);
            tick();
            if (i == 3) chk("cov_half", cov, 8'h0F);
        end
        chk("cov_full", cov, 8'hFF);

        // Partial sweep, then reset mid-sweep.
        for (int i = 0; i < 3; i++) begin
            v = i[2:0];
            drive(v[2], v[1], v[0], 1'b0);
            tick();
        end
        chk("cov_sticky", cov, 8'hFF);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midsweep_cov", cov, 8'h00);
        chk("midsweep_S_q", {7'b0, S_q}, 8'h00);
        chk("midsweep_S_comb", {7'b0, S}, 8'h00);
        chk("midsweep_Cout_comb", {7'b0, Cout}, 8'h01);
        tick();
        chk("midsweep_cov_held", cov, 8'h00);

        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
